// File: rtl/audio_mode_sequencer.sv
// Mode sequencer for the audio processing blocks: glitch-free mute/drain/switch/arm
// transitions between mutually exclusive modes, plus the independent Ethernet enable.
module audio_mode_sequencer #(
    parameter int unsigned SETTLE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [3:0] ctrl_command,
    input  logic [3:0] value_command,
    input  logic       lrck,
    output logic       tone_en,
    output logic       echo_en,
    output logic       backgm_en,
    output logic       voice_en,
    output logic       eth_en,
    output logic       mute,
    output logic       busy,
    output logic [2:0] cur_mode,
    output logic       cmd_ack,
    output logic       cmd_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;
    localparam logic [1:0] ST_ARM    = 2'd3;

    localparam logic [2:0] MODE_BYPASS = 3'd0;
    localparam logic [2:0] MODE_TONE   = 3'd1;
    localparam logic [2:0] MODE_ECHO   = 3'd2;
    localparam logic [2:0] MODE_BACKGM = 3'd3;
    localparam logic [2:0] MODE_VOICE  = 3'd4;

    localparam logic [7:0] LAST_CNT = 8'(SETTLE_FRAMES - 1);

    // Enable vector ordered {voice, backgm, echo, tone}; bypass drives nothing.
    function automatic logic [3:0] mode_enables(input logic [2:0] mode);
        logic [3:0] en;
        case (mode)
            MODE_TONE:   en = 4'b0001;
            MODE_ECHO:   en = 4'b0010;
            MODE_BACKGM: en = 4'b0100;
            MODE_VOICE:  en = 4'b1000;
            default:     en = 4'b0000;
        endcase
        return en;
    endfunction

    logic       lrck_meta_r, lrck_sync_r, lrck_dly_r;
    logic       frame_pulse_s;
    logic [1:0] state_r, nxt_state_s;
    logic [2:0] cur_mode_r, nxt_cur_mode_s;
    logic [2:0] target_r, nxt_target_s;
    logic       pend_valid_r, nxt_pend_valid_s;
    logic [2:0] pend_mode_r, nxt_pend_mode_s;
    logic [7:0] cnt_r, nxt_cnt_s;
    logic       mode_req_s, eth_set_s, eth_clr_s, illegal_s;
    logic [2:0] req_mode_s;
    logic       phase_done_s, exit_valid_s;
    logic [2:0] exit_mode_s;
    logic [3:0] en_r;
    logic       eth_en_r, mute_r, busy_r, cmd_ack_r, cmd_err_r;

    // Synchronise lrck and keep a delayed copy for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lrck_meta_r <= 1'b0;
            lrck_sync_r <= 1'b0;
            lrck_dly_r  <= 1'b0;
        end else begin
            lrck_meta_r <= lrck;
            lrck_sync_r <= lrck_meta_r;
            lrck_dly_r  <= lrck_sync_r;
        end
    end

    assign frame_pulse_s = lrck_sync_r & ~lrck_dly_r;

    // Command decode.
    always_comb begin
        mode_req_s = 1'b0;
        req_mode_s = MODE_BYPASS;
        eth_set_s  = 1'b0;
        eth_clr_s  = 1'b0;
        illegal_s  = 1'b0;
        if (cmd_valid) begin
            case (ctrl_command)
                4'b0010: begin
                    mode_req_s = 1'b1;
                    case (value_command)
                        4'b0001: req_mode_s = MODE_TONE;
                        4'b0010: req_mode_s = MODE_ECHO;
                        4'b0011: req_mode_s = MODE_BACKGM;
                        default: req_mode_s = MODE_BYPASS;
                    endcase
                end
                4'b1001: begin
                    mode_req_s = 1'b1;
                    req_mode_s = MODE_VOICE;
                end
                4'b0000: mode_req_s = 1'b1;
                4'b0100: eth_set_s = 1'b1;
                4'b1000: eth_clr_s = 1'b1;
                default: illegal_s = 1'b1;
            endcase
        end else begin
            illegal_s = 1'b0;
        end
    end

    // A request landing on the ARM exit cycle supersedes the stored one.
    assign phase_done_s = frame_pulse_s && (cnt_r == LAST_CNT);
    assign exit_valid_s = mode_req_s || pend_valid_r;
    assign exit_mode_s  = mode_req_s ? req_mode_s : pend_mode_r;

    // Next-state logic for the transition FSM and pending slot.
    always_comb begin
        nxt_state_s      = state_r;
        nxt_cur_mode_s   = cur_mode_r;
        nxt_target_s     = target_r;
        nxt_pend_valid_s = pend_valid_r;
        nxt_pend_mode_s  = pend_mode_r;
        nxt_cnt_s        = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (mode_req_s && (req_mode_s != cur_mode_r)) begin
                    nxt_state_s  = ST_DRAIN;
                    nxt_target_s = req_mode_s;
                    nxt_cnt_s    = 8'd0;
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_DRAIN, ST_SWITCH: begin
                if (mode_req_s) begin
                    nxt_pend_valid_s = 1'b1;
                    nxt_pend_mode_s  = req_mode_s;
                end else begin
                    nxt_pend_valid_s = pend_valid_r;
                end
                if (state_r == ST_SWITCH) begin
                    nxt_state_s = ST_ARM;
                    nxt_cnt_s   = 8'd0;
                end else if (phase_done_s) begin
                    nxt_state_s    = ST_SWITCH;
                    nxt_cur_mode_s = target_r;
                end else if (frame_pulse_s) begin
                    nxt_cnt_s = cnt_r + 8'd1;
                end else begin
                    nxt_cnt_s = cnt_r;
                end
            end
            ST_ARM: begin
                if (phase_done_s) begin
                    nxt_pend_valid_s = 1'b0;
                    if (exit_valid_s && (exit_mode_s != cur_mode_r)) begin
                        nxt_state_s  = ST_DRAIN;
                        nxt_target_s = exit_mode_s;
                        nxt_cnt_s    = 8'd0;
                    end else begin
                        nxt_state_s = ST_IDLE;
                    end
                end else begin
                    if (mode_req_s) begin
                        nxt_pend_valid_s = 1'b1;
                        nxt_pend_mode_s  = req_mode_s;
                    end else begin
                        nxt_pend_valid_s = pend_valid_r;
                    end
                    if (frame_pulse_s) begin
                        nxt_cnt_s = cnt_r + 8'd1;
                    end else begin
                        nxt_cnt_s = cnt_r;
                    end
                end
            end
            default: nxt_state_s = ST_IDLE;
        endcase
    end

    // State, pending slot and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cur_mode_r   <= MODE_BYPASS;
            target_r     <= MODE_BYPASS;
            pend_valid_r <= 1'b0;
            pend_mode_r  <= MODE_BYPASS;
            cnt_r        <= 8'd0;
            en_r         <= 4'b0000;
            eth_en_r     <= 1'b0;
            mute_r       <= 1'b0;
            busy_r       <= 1'b0;
            cmd_ack_r    <= 1'b0;
            cmd_err_r    <= 1'b0;
        end else begin
            state_r      <= nxt_state_s;
            cur_mode_r   <= nxt_cur_mode_s;
            target_r     <= nxt_target_s;
            pend_valid_r <= nxt_pend_valid_s;
            pend_mode_r  <= nxt_pend_mode_s;
            cnt_r        <= nxt_cnt_s;
            en_r         <= (nxt_state_s == ST_SWITCH) ? 4'b0000 : mode_enables(nxt_cur_mode_s);
            eth_en_r     <= eth_set_s ? 1'b1 : (eth_clr_s ? 1'b0 : eth_en_r);
            mute_r       <= (nxt_state_s != ST_IDLE);
            busy_r       <= (nxt_state_s != ST_IDLE);
            cmd_ack_r    <= mode_req_s | eth_set_s | eth_clr_s;
            cmd_err_r    <= illegal_s;
        end
    end

    assign tone_en   = en_r[0];
    assign echo_en   = en_r[1];
    assign backgm_en = en_r[2];
    assign voice_en  = en_r[3];
    assign eth_en    = eth_en_r;
    assign mute      = mute_r;
    assign busy      = busy_r;
    assign cur_mode  = cur_mode_r;
    assign cmd_ack   = cmd_ack_r;
    assign cmd_err   = cmd_err_r;

endmodule

// File: tb/tb_audio_mode_sequencer.sv
// Scoreboard bench for audio_mode_sequencer: command responses and committed
// mode sequence are queued at stimulus time and compared when the DUT reacts.
module tb_audio_mode_sequencer;

    localparam logic [1:0] RESP_ACK = 2'b10;
    localparam logic [1:0] RESP_ERR = 2'b01;
    localparam int         BUDGET   = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [3:0] ctrl_command = 4'd0;
    logic [3:0] value_command = 4'd0;
    logic       lrck = 1'b0;
    logic       tone_en, echo_en, backgm_en, voice_en;
    logic       eth_en, mute, busy, cmd_ack, cmd_err;
    logic [2:0] cur_mode;

    int n_checks = 0;
    int n_pass   = 0;
    int frames   = 0;
    int mode_q[$];
    int resp_q[$];
    int last_mode = 0;
    logic cv_d = 1'b0;

    audio_mode_sequencer #(.SETTLE_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid),
        .ctrl_command(ctrl_command), .value_command(value_command), .lrck(lrck),
        .tone_en(tone_en), .echo_en(echo_en), .backgm_en(backgm_en), .voice_en(voice_en),
        .eth_en(eth_en), .mute(mute), .busy(busy), .cur_mode(cur_mode),
        .cmd_ack(cmd_ack), .cmd_err(cmd_err)
    );

    always #10 clk = ~clk;
    always #10417 lrck = ~lrck;
    always @(posedge lrck) frames = frames + 1;
    always @(posedge clk) cv_d <= cmd_valid;

    task automatic check(input string tag, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int all_outs();
        return int'({tone_en, echo_en, backgm_en, voice_en, eth_en, mute, busy,
                     cur_mode, cmd_ack, cmd_err});
    endfunction

    function automatic int en_vec();
        return int'({voice_en, backgm_en, echo_en, tone_en});
    endfunction

    task automatic send_cmd(input logic [3:0] c, input logic [3:0] v, input logic [1:0] exp_resp);
        @(negedge clk);
        ctrl_command  = c;
        value_command = v;
        cmd_valid     = 1'b1;
        resp_q.push_back(int'(exp_resp));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("cmd_resp", int'({cmd_ack, cmd_err}), resp_q.pop_front());
    endtask

    // Keep commands well away from lrck edges so frame counts are unambiguous.
    task automatic align();
        @(posedge lrck);
        repeat (10) step();
    endtask

    // Committed-mode scoreboard, exclusivity and spurious-response monitor.
    always begin
        @(posedge clk);
        #1;
        if (rst_n && (int'(cur_mode) != last_mode)) begin
            if (mode_q.size() > 0) check("mode_seq", int'(cur_mode), mode_q.pop_front());
            else check("mode_unexp", int'(cur_mode), last_mode);
        end
        last_mode = int'(cur_mode);
        if ($countones({tone_en, echo_en, backgm_en, voice_en}) > 1)
            check("onehot", $countones({tone_en, echo_en, backgm_en, voice_en}), 1);
        if ((cmd_ack || cmd_err) && !cv_d)
            check("spurious_resp", int'({cmd_ack, cmd_err}), 0);
    end

    initial begin
        int f0, f1, zeros, bad, mute_gap, voice_seen;

        repeat (3) step();
        check("reset_outs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // BYPASS -> TONE
        align();
        f0 = frames;
        mode_q.push_back(1);
        send_cmd(4'b0010, 4'b0001, RESP_ACK);
        check("t1_mute_n1", int'(mute), 1);
        check("t1_busy_n1", int'(busy), 1);
        for (int i = 0; i < BUDGET && !tone_en; i++) step();
        check("t1_tone_rise", int'(tone_en), 1);
        check("t1_drain_frames", frames - f0, 2);
        check("t1_mode_arm", int'(cur_mode), 1);
        check("t1_mute_arm", int'(mute), 1);
        f1 = frames;
        for (int i = 0; i < BUDGET && mute; i++) step();
        check("t1_unmute", int'(mute), 0);
        check("t1_arm_frames", frames - f1, 2);
        check("t1_busy_end", int'(busy), 0);
        check("t1_tone_end", int'(tone_en), 1);

        // TONE -> ECHO, then VOICE and BACKGM while busy (last wins)
        align();
        f0 = frames;
        mode_q.push_back(2);
        send_cmd(4'b0010, 4'b0010, RESP_ACK);
        repeat (5) step();
        send_cmd(4'b1001, 4'b0000, RESP_ACK);
        repeat (3) step();
        mode_q.push_back(3);
        send_cmd(4'b0010, 4'b0011, RESP_ACK);
        zeros = 0;
        bad = 0;
        for (int i = 0; i < BUDGET && !echo_en; i++) begin
            step();
            if (en_vec() == 0) zeros++;
            else if (!echo_en && en_vec() != 1) bad++;
        end
        check("t2_echo_rise", int'(echo_en), 1);
        check("t2_switch_gap", zeros, 1);
        check("t2_drain_en", bad, 0);
        check("t2_drain_frames", frames - f0, 2);
        mute_gap = 0;
        voice_seen = 0;
        for (int i = 0; i < BUDGET && busy; i++) begin
            step();
            if (busy && !mute) mute_gap++;
            if (voice_en) voice_seen++;
        end
        check("t3_busy_end", int'(busy), 0);
        check("t3_mute_gap", mute_gap, 0);
        check("t3_voice_seen", voice_seen, 0);
        check("t3_backgm_en", int'(backgm_en), 1);
        check("t3_total_frames", frames - f0, 8);

        // Ethernet commands and an illegal one during BACKGM -> BYPASS
        align();
        f0 = frames;
        mode_q.push_back(0);
        send_cmd(4'b0000, 4'b0000, RESP_ACK);
        check("t4_busy", int'(busy), 1);
        repeat (20) step();
        send_cmd(4'b0100, 4'b0000, RESP_ACK);
        check("t4_eth_set", int'(eth_en), 1);
        repeat (20) step();
        send_cmd(4'b1000, 4'b0000, RESP_ACK);
        check("t4_eth_clr", int'(eth_en), 0);
        repeat (4) step();
        send_cmd(4'b0111, 4'b0000, RESP_ERR);
        check("t4_err_busy", int'(busy), 1);
        check("t4_err_mode", int'(cur_mode), 3);
        check("t4_err_eth", int'(eth_en), 0);
        for (int i = 0; i < BUDGET && busy; i++) step();
        check("t4_busy_end", int'(busy), 0);
        check("t4_frames", frames - f0, 4);
        check("t4_bypass_en", en_vec(), 0);

        // Reset in the middle of ARM
        send_cmd(4'b0100, 4'b0000, RESP_ACK);
        check("t5_eth_on", int'(eth_en), 1);
        align();
        mode_q.push_back(1);
        send_cmd(4'b0010, 4'b0001, RESP_ACK);
        for (int i = 0; i < BUDGET && !tone_en; i++) step();
        check("t5_in_arm", int'(tone_en & mute), 1);
        repeat (3) step();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t5_reset_outs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send_cmd(4'b0000, 4'b0000, RESP_ACK);
        check("t5_same_busy", int'(busy), 0);
        check("t5_same_mute", int'(mute), 0);
        repeat (5) step();
        check("t5_same_idle", int'(busy), 0);
        check("mode_q_left", mode_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_mode_sequencer.md
# audio_mode_sequencer

Sequences the mutually exclusive audio-processing modes (tone adjust, echo reduction, background reduction, voice recognition) from UART control commands. It also owns the independent Ethernet-streaming enable. It sits between the UART command decoder and the processing blocks in the 50 MHz domain. Every mode change is glitch-free: output is muted, the old block drains for a fixed number of audio frames, and the new block is armed before unmuting.

## Interface
- SETTLE_FRAMES, 4: audio frames (LRCK rising edges) waited in each of the drain and arm phases; legal range 1..255.
- clk  in  1  processing clock (clk_50M).
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  one-cycle strobe; ctrl_command/value_command are valid.
- ctrl_command  in  4  command class.
- value_command  in  4  command argument.
- lrck  in  1  codec frame clock, asynchronous to clk; synchronised internally.
- tone_en, echo_en, backgm_en, voice_en  out  1 each  mode enables; at most one is high.
- eth_en  out  1  Ethernet streaming enable.
- mute  out  1  forces the DAC path to zero while high.
- busy  out  1  a mode transition is in progress.
- cur_mode  out  3  committed mode: 0 BYPASS, 1 TONE, 2 ECHO, 3 BACKGM, 4 VOICE.
- cmd_ack  out  1  one-cycle pulse when a legal command is accepted.
- cmd_err  out  1  one-cycle pulse when an illegal command is received.

## Operation
- Decode of a command with cmd_valid=1:
  - ctrl 0010: value 0001 targets TONE, 0010 targets ECHO, 0011 targets BACKGM, any other value targets BYPASS.
  - ctrl 1001 targets VOICE; ctrl 0000 targets BYPASS.
  - ctrl 0100 sets eth_en=1; ctrl 1000 clears eth_en. Both take effect the next cycle, do not touch the FSM, and are legal while busy.
  - Any other ctrl value raises cmd_err and changes no state.
- Mode request with target == cur_mode while IDLE: cmd_ack only, no sequencing.
- FSM states:
  - IDLE: mute=0, busy=0. A mode request goes to DRAIN.
  - DRAIN: mute=1, busy=1. The old enable stays high. After SETTLE_FRAMES frame pulses, go to SWITCH.
  - SWITCH: one cycle with all four mode enables low. cur_mode is updated to the target. Go to ARM.
  - ARM: mute=1, busy=1. The new enable is high; BYPASS has no enable. After SETTLE_FRAMES frame pulses, go to IDLE.
- Pending slot: one entry.
  - A mode request arriving while busy is acked and stored; a later request overwrites it (last wins).
  - On entering IDLE with a valid pending entry that differs from cur_mode, go straight to DRAIN on the same cycle; mute stays 1 with no unmute gap.
  - A pending entry equal to cur_mode is discarded.
- Frame pulse:
  - lrck passes through a 2-flop synchroniser plus one delay flop.
  - The pulse is the one-cycle rising-edge detect of the synchronised signal.
  - The frame counter is 8 bits. It clears on entry to DRAIN and to ARM, and increments on each frame pulse in those states.
  - The phase exits when count == SETTLE_FRAMES-1 and a frame pulse occurs.
- Enables are registered outputs decoded from state and mode; never combinational from the inputs.

## Timing
- Reset values: all enables 0, eth_en 0, mute 0, busy 0, cur_mode 0, cmd_ack 0, cmd_err 0; pending slot, counter and synchroniser cleared; state IDLE.
- Reset mid-transition returns everything to the reset values on the next edge, including mute=0 and cur_mode=BYPASS.
- Command latency (cmd_valid at cycle N):
  - cmd_ack or cmd_err is high at cycle N+1.
  - State is DRAIN at N+1, and mute/busy are high at N+1.
  - eth_en changes at N+1.
- lrck edge to frame pulse: 3 clk cycles.
- Transition duration: 2×SETTLE_FRAMES frames plus one SWITCH cycle plus synchroniser skew.
- The old enable falls on entering SWITCH. The new enable rises exactly one cycle later.
- cmd_valid coinciding with the SWITCH or exit cycle goes to the pending slot; the command is never lost.

## Test plan
- Reset, then SETTLE_FRAMES=2 with ctrl 0010/value 0001 and lrck at 48 kHz:
  - ack at N+1, mute=1 at N+1.
  - tone_en rises after 2 frames plus 1 cycle.
  - mute falls after 2 more frames; cur_mode=1.
- In TONE, send ctrl 0010/value 0010:
  - tone_en stays high through DRAIN, then one cycle with all enables low, then echo_en high; cur_mode=2.
  - At no cycle are two enables high.
- While busy toward ECHO, send VOICE then BACKGM:
  - both acked.
  - After ECHO's ARM, the sequencer goes directly to DRAIN with mute held 1, and finishes in BACKGM (cur_mode=3); VOICE never asserts.
- Send ctrl 0100 mid-transition, then ctrl 1000, then ctrl 0111:
  - eth_en goes 1 then 0, each one cycle after its command.
  - FSM timing is unaffected.
  - ctrl 0111 produces cmd_err and no state change.
- Assert rst_n=0 for one cycle during ARM:
  - all outputs return to reset values next cycle.
  - A repeat command to the current mode in IDLE gives ack only, busy stays 0.
